// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared FSM state type, default timing constants and button bit indices.
package button_conditioner_pkg;
  typedef enum logic [1:0] {IDLE, ARM_PRESS, PRESSED, ARM_RELEASE} btn_state_e;
  localparam int N_BTN_DEF = 3;
  localparam logic [19:0] DEBOUNCE_DEF = 20'd1_000_000;
  localparam logic [27:0] HOLD_DEF = 28'd50_000_000;
  localparam logic [27:0] REPEAT_DEF = 28'd10_000_000;
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and conditioned level/strobe outputs.
interface button_conditioner_if
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  modport master (output btn_in, input btn_level, btn_press, btn_release, btn_repeat);
  modport slave (input btn_in, output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/button_channel.sv
// button_channel: synchronizer, debounce FSM and auto-repeat timer for one button.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic [27:0] HOLD_CYCLES = HOLD_DEF,
  parameter logic [27:0] REPEAT_CYCLES = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
  // Entry into an ARM state is the first stable cycle, so the exit compare is one short.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 20'd2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 28'd1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 28'd1);
  btn_state_e state_q, state_d;
  logic s1_q, s2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic rep_q, rep_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, rpt_q, rpt_d;
  logic [HW-1:0] hold_tgt;
  assign hold_tgt = rep_q ? REP_LAST : HOLD_LAST;
  always_comb begin
    state_d = state_q;
    dcnt_d = (dcnt_q == '1) ? dcnt_q : dcnt_q + DW'(1);
    hcnt_d = hcnt_q;
    rep_d = rep_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    rpt_d = 1'b0;
    case (state_q)
      IDLE: if (s2_q) begin
        state_d = ARM_PRESS;
        dcnt_d = '0;
      end
      ARM_PRESS: if (!s2_q) state_d = IDLE;
      else if (dcnt_q == DB_LAST) begin
        state_d = PRESSED;
        level_d = 1'b1;
        press_d = 1'b1;
        hcnt_d = '0;
        rep_d = 1'b0;
      end
      PRESSED: if (!s2_q) begin
        state_d = ARM_RELEASE;
        dcnt_d = '0;
      end else if (hcnt_q == hold_tgt) begin
        rpt_d = 1'b1;
        hcnt_d = '0;
        rep_d = 1'b1;
      end else hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + HW'(1);
      ARM_RELEASE: if (s2_q) begin
        state_d = PRESSED;
        hcnt_d = '0;
        rep_d = 1'b0;
      end else if (dcnt_q == DB_LAST) begin
        state_d = IDLE;
        level_d = 1'b0;
        rel_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      dcnt_q <= '0;
      hcnt_q <= '0;
      rep_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      rpt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= btn_in;
      s2_q <= s1_q;
      dcnt_q <= dcnt_d;
      hcnt_q <= hcnt_d;
      rep_q <= rep_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
      rpt_q <= rpt_d;
    end
  end
  assign btn_level = level_q;
  assign btn_press = press_q;
  assign btn_release = rel_q;
  assign btn_repeat = rpt_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN independent debounce/strobe/auto-repeat channels.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic [27:0] HOLD_CYCLES = HOLD_DEF,
  parameter logic [27:0] REPEAT_CYCLES = REPEAT_DEF
) (
  input logic clk,
  input logic rst_n,
  button_conditioner_if.slave bus
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .btn_in(bus.btn_in[i]),
      .btn_level(bus.btn_level[i]),
      .btn_press(bus.btn_press[i]),
      .btn_release(bus.btn_release[i]),
      .btn_repeat(bus.btn_repeat[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with an expected-event queue checked by a strobe monitor.
module tb_button_conditioner;
  import button_conditioner_pkg::*;
  typedef struct {
    int cyc;
    logic [2:0] lvl, press, rel, rep;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  ev_t q[$];
  ev_t e;
  button_conditioner_if #(.N_BTN(3)) bi ();
  button_conditioner #(
    .N_BTN(3),
    .DEBOUNCE_CYCLES(20'd8),
    .HOLD_CYCLES(28'd20),
    .REPEAT_CYCLES(28'd5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [43:0] got, input logic [43:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got cyc=%0d lvl/press/rel/rep=%h, expected cyc=%0d lvl/press/rel/rep=%h",
                  name, got[43:12], got[11:0], exp[43:12], exp[11:0]);
  endtask
  task automatic push(input int c, input logic [2:0] lvl, press, rel, rep);
    q.push_back('{c, lvl, press, rel, rep});
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  function automatic logic [43:0] outs();
    return {32'(cyc), bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_repeat};
  endfunction
  always @(negedge clk) begin
    if (rst_n && (bi.btn_press | bi.btn_release | bi.btn_repeat) != 3'b000) begin
      if (q.size() == 0) chk("unexpected_strobe", outs(), {32'(cyc), bi.btn_level, 9'd0});
      else begin
        e = q.pop_front();
        chk("event", outs(), {32'(e.cyc), e.lvl, e.press, e.rel, e.rep});
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    bi.btn_in = 3'b000;
    wait_cyc(3);
    chk("reset", outs(), {32'd3, 12'd0});
    rst_n = 1'b1;
    // clean press on btnC, then a 4-cycle release bounce and a real release
    wait_cyc(9);
    bi.btn_in[BTN_C] = 1'b1;
    push(19, 3'b001, 3'b001, 3'b000, 3'b000);
    push(48, 3'b001, 3'b000, 3'b000, 3'b001);
    push(58, 3'b000, 3'b000, 3'b001, 3'b000);
    wait_cyc(21);
    bi.btn_in[BTN_C] = 1'b0;
    wait_cyc(25);
    bi.btn_in[BTN_C] = 1'b1;
    wait_cyc(48);
    bi.btn_in[BTN_C] = 1'b0;
    // press bounce on btnL: 5 high, 3 low, 6 high
    wait_cyc(60);
    bi.btn_in[BTN_L] = 1'b1;
    wait_cyc(65);
    bi.btn_in[BTN_L] = 1'b0;
    wait_cyc(68);
    bi.btn_in[BTN_L] = 1'b1;
    wait_cyc(74);
    bi.btn_in[BTN_L] = 1'b0;
    wait_cyc(85);
    chk("bounce_level", outs(), {32'd85, 12'd0});
    // auto-repeat on btnR
    wait_cyc(90);
    bi.btn_in[BTN_R] = 1'b1;
    push(100, 3'b100, 3'b100, 3'b000, 3'b000);
    for (int k = 0; k < 7; k++) push(120 + 5 * k, 3'b100, 3'b000, 3'b000, 3'b100);
    push(160, 3'b000, 3'b000, 3'b100, 3'b000);
    wait_cyc(150);
    bi.btn_in[BTN_R] = 1'b0;
    // simultaneous btnC + btnR
    wait_cyc(170);
    bi.btn_in = 3'b101;
    push(180, 3'b101, 3'b101, 3'b000, 3'b000);
    push(195, 3'b000, 3'b000, 3'b101, 3'b000);
    wait_cyc(185);
    bi.btn_in = 3'b000;
    // reset while btnL is pressed and held
    wait_cyc(200);
    bi.btn_in[BTN_L] = 1'b1;
    push(210, 3'b010, 3'b010, 3'b000, 3'b000);
    push(228, 3'b010, 3'b010, 3'b000, 3'b000);
    push(240, 3'b000, 3'b000, 3'b010, 3'b000);
    wait_cyc(215);
    rst_n = 1'b0;
    for (int k = 216; k <= 218; k++) begin
      wait_cyc(k);
      chk("reset_mid_press", outs(), {32'(k), 12'd0});
    end
    rst_n = 1'b1;
    wait_cyc(230);
    bi.btn_in[BTN_L] = 1'b0;
    wait_cyc(260);
    chk("events_drained", 44'(q.size()), 44'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
